// File: rtl/steer_pkg.sv
// steer_pkg: shared thresholds, timer widths and sample type for the steering-enable conditioning stage
package steer_pkg;
  localparam logic [11:0] MIN_RIDER_WEIGHT_DEF = 12'h200;
  localparam logic [11:0] WT_HYSTERESIS_DEF = 12'h040;
  localparam int TMR_W_FULL = 26;
  localparam int TMR_W_FAST = 15;
  typedef logic [11:0] ld_t;
endpackage

// File: rtl/load_avg4.sv
// load_avg4: 4-sample moving average of one load cell, history shifts only on vld
module load_avg4
  import steer_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic vld,
  input  ld_t  smpl,
  output ld_t  avg
);
  ld_t hist_q [4];
  ld_t hist_d [4];
  logic [13:0] acc;
  always_comb begin
    hist_d = hist_q;
    if (vld) begin
      hist_d[0] = smpl;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist_q <= '{default: '0};
    else hist_q <= hist_d;
  end
  assign acc = 14'(hist_q[0]) + 14'(hist_q[1]) + 14'(hist_q[2]) + 14'(hist_q[3]);
  assign avg = acc[13:2];
endmodule

// File: rtl/steer_en_cond.sv
// steer_en_cond: averages left/right load cells, derives weight/position flags and runs the settle timer
module steer_en_cond
  import steer_pkg::*;
#(
  parameter logic [11:0] MIN_RIDER_WEIGHT = MIN_RIDER_WEIGHT_DEF,
  parameter logic [11:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF,
  parameter bit FAST_SIM = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vld,
  input  logic [11:0] lft_ld,
  input  logic [11:0] rght_ld,
  input  logic        clr_tmr,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16,
  output logic        tmr_full
);
  localparam int TW = FAST_SIM ? TMR_W_FAST : TMR_W_FULL;
  localparam logic [12:0] HI = 13'(MIN_RIDER_WEIGHT) + 13'(WT_HYSTERESIS);
  localparam logic [12:0] LO = 13'(MIN_RIDER_WEIGHT) - 13'(WT_HYSTERESIS);
  localparam logic [TW-1:0] ONE = 1;
  ld_t lft_avg, rght_avg;
  logic [12:0] sum, diff;
  logic vld_q, vld_d;
  logic [3:0] flg_q, flg_d;
  logic [TW-1:0] cnt_q, cnt_d;
  load_avg4 u_lft (.clk(clk), .rst_n(rst_n), .vld(vld), .smpl(lft_ld), .avg(lft_avg));
  load_avg4 u_rght (.clk(clk), .rst_n(rst_n), .vld(vld), .smpl(rght_ld), .avg(rght_avg));
  // flags are evaluated one cycle after capture, once the averages reflect the new sample
  always_comb begin
    vld_d = vld;
    sum = 13'(lft_avg) + 13'(rght_avg);
    diff = {1'b0, (lft_avg >= rght_avg) ? lft_avg - rght_avg : rght_avg - lft_avg};
    flg_d = vld_q ? {sum > HI, sum < LO, diff > (sum >> 2), diff > (sum - (sum >> 4))} : flg_q;
    cnt_d = clr_tmr ? '0 : (tmr_full ? cnt_q : cnt_q + ONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      flg_q <= 4'b0100;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      flg_q <= flg_d;
      cnt_q <= cnt_d;
    end
  end
  assign {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16} = flg_q;
  assign tmr_full = &cnt_q;
endmodule

// File: tb/tb_steer_en_cond.sv
// tb_steer_en_cond: directed checks of averaging, flags, latency, reset and fast settle timer
module tb_steer_en_cond;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld = 1'b0;
  logic [11:0] lft = '0;
  logic [11:0] rght = '0;
  logic clr_tmr = 1'b0;
  logic sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16, tmr_full;
  int checks = 0;
  int errors = 0;
  logic [3:0] flags;
  assign flags = {sum_gt_min, sum_lt_min, diff_gt_1_4, diff_gt_15_16};

  steer_en_cond #(.FAST_SIM(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .vld(vld), .lft_ld(lft), .rght_ld(rght), .clr_tmr(clr_tmr),
    .sum_gt_min(sum_gt_min), .sum_lt_min(sum_lt_min), .diff_gt_1_4(diff_gt_1_4),
    .diff_gt_15_16(diff_gt_15_16), .tmr_full(tmr_full)
  );

  always #5 clk = ~clk;

  task automatic strobe(input logic [11:0] l, input logic [11:0] r);
    @(negedge clk);
    vld = 1'b1;
    lft = l;
    rght = r;
    @(negedge clk);
    vld = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({flags, tmr_full} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_vals: got flags=%b tmr_full=%b, need flags=0100 tmr_full=0", flags, tmr_full);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp;
    logic [3:0] exp [4];
    exp = '{4'b0100, 4'b0100, 4'b0000, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      strobe(12'h150, 12'h150);
      checks++;
      if (flags !== exp[i]) begin
        errors++;
        $display("FAIL ramp_s%0d: got {gt,lt,d14,d1516}=%b need %b", i + 1, flags, exp[i]);
      end
    end
  endtask

  task automatic test_hold;
    @(negedge clk);
    lft = 12'hfff;
    rght = 12'h000;
    repeat (3) @(negedge clk);
    checks++;
    if (flags !== 4'b1000) begin
      errors++;
      $display("FAIL hold_no_vld: got %b need 1000", flags);
    end
  endtask

  task automatic test_moderate;
    repeat (4) strobe(12'h180, 12'h080);
    checks++;
    if (flags !== 4'b0010) begin
      errors++;
      $display("FAIL moderate: got {gt,lt,d14,d1516}=%b need 0010", flags);
    end
  endtask

  task automatic test_stepping;
    repeat (4) strobe(12'h300, 12'h000);
    checks++;
    if (flags !== 4'b1011) begin
      errors++;
      $display("FAIL stepping_off: got {gt,lt,d14,d1516}=%b need 1011", flags);
    end
  endtask

  task automatic test_back_to_back;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (flags !== 4'b0100) begin
          errors++;
          $display("FAIL b2b_s2: got %b need 0100", flags);
        end
      end
      vld = 1'b1;
      lft = 12'h150;
      rght = 12'h150;
    end
    @(negedge clk);
    vld = 1'b0;
    checks++;
    if (flags !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_s3: got %b need 0000", flags);
    end
    @(negedge clk);
    checks++;
    if (flags !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_s4: got %b need 1000", flags);
    end
  endtask

  task automatic test_timer;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (32766) @(negedge clk);
    checks++;
    if (tmr_full !== 1'b0) begin
      errors++;
      $display("FAIL tmr_early: got %b need 0 after 32766 edges", tmr_full);
    end
    @(negedge clk);
    checks++;
    if (tmr_full !== 1'b1) begin
      errors++;
      $display("FAIL tmr_full_at_32767: got %b need 1", tmr_full);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (tmr_full !== 1'b1) begin
      errors++;
      $display("FAIL tmr_saturate: got %b need 1", tmr_full);
    end
    clr_tmr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (tmr_full !== 1'b0) begin
        errors++;
        $display("FAIL tmr_clr_wins_%0d: got %b need 0", i, tmr_full);
      end
    end
    clr_tmr = 1'b0;
    @(negedge clk);
    checks++;
    if (tmr_full !== 1'b0) begin
      errors++;
      $display("FAIL tmr_restart: got %b need 0", tmr_full);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_ramp();
    test_hold();
    test_moderate();
    test_stepping();
    test_reset();
    test_ramp();
    test_back_to_back();
    test_timer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
